// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the endian lane-index helper used by the lane datapath.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_RD  = 3'd1,
    ST_WR  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5,
    ERR    = 3'd6
  } lsu_state_t;

  // Maps a byte/half index to its physical lane; 'last' is the highest lane index.
  function automatic logic [1:0] lane_index(input logic [1:0] idx, input logic [1:0] last,
                                            input logic big);
    return big ? (last - idx) : idx;
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane datapath: extracts and extends loaded bytes/halves and
// merges sub-word store data into a previously read word.
module lsu_lane_unit
  import mips_lsu_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  localparam logic BIG = (BIG_ENDIAN != 0);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] shifted;
  logic [1:0]  byte_lane;
  logic [1:0]  half_lane;

  assign byte_lane = lane_index(addr_lo, 2'd3, BIG);
  assign half_lane = lane_index({1'b0, addr_lo[1]}, 2'd1, BIG);

  always_comb begin
    shamt = 5'd0;
    mask  = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        shamt = {byte_lane, 3'b000};
        mask  = 32'h0000_00FF;
      end
      SZ_HALF: begin
        shamt = {half_lane[0], 4'b0000};
        mask  = 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

  assign shifted = word >> shamt;

  always_comb begin
    rdata = shifted;
    case (size)
      SZ_BYTE: rdata = sgn ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      SZ_HALF: rdata = sgn ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

  // Sub-word stores keep every lane outside the addressed one untouched.
  assign merged = (old_word & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// Initiator of the word-only data-memory port: accepts byte/half/word requests,
// performs sub-word stores as read-modify-write and reports misaligned/out-of-range errors.
module load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state_reg;
  logic [31:0] addr_reg;
  logic [1:0]  size_reg;
  logic        sgn_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;
  logic [31:0] rdata_reg;
  logic        err_wait_reg;

  logic        accept;
  logic        req_bad;
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  assign accept = req_valid & req_ready;

  assign req_bad = (req_size == 2'b11)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                 | (req_addr[31:DEPTH+2] != '0);

  lsu_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .word     (mem_rd),
    .addr_lo  (addr_reg[1:0]),
    .size     (size_reg),
    .sgn      (sgn_reg),
    .old_word (word_reg),
    .wdata    (wdata_reg),
    .rdata    (lane_rdata),
    .merged   (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      size_reg     <= '0;
      sgn_reg      <= 1'b0;
      wdata_reg    <= '0;
      word_reg     <= '0;
      rdata_reg    <= '0;
      err_wait_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg  <= req_addr;
            size_reg  <= req_size;
            sgn_reg   <= req_signed;
            wdata_reg <= req_wdata;
            rdata_reg <= '0;
            if (req_bad) begin
              state_reg    <= ERR;
              err_wait_reg <= 1'b1;
            end else if (!req_we) begin
              state_reg <= LD_RD;
            end else if (req_size == SZ_WORD) begin
              state_reg <= ST_WR;
            end else begin
              state_reg <= RMW_RD;
            end
          end
        end
        LD_RD: begin
          rdata_reg <= lane_rdata;
          state_reg <= RESP;
        end
        ST_WR:  state_reg <= RESP;
        RMW_RD: begin
          word_reg  <= mem_rd;
          state_reg <= RMW_WR;
        end
        RMW_WR: state_reg <= RESP;
        RESP:   state_reg <= IDLE;
        ERR: begin
          // Errors spend one quiet cycle here so they complete with load latency.
          if (err_wait_reg) err_wait_reg <= 1'b0;
          else              state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Every output is gated by reset_n so nothing leaks out during a reset cycle.
  assign req_ready = reset_n && (state_reg == IDLE);
  assign rsp_err   = reset_n && (state_reg == ERR) && !err_wait_reg;
  assign rsp_valid = (reset_n && (state_reg == RESP)) || rsp_err;
  assign rsp_rdata = (reset_n && (state_reg == RESP)) ? rdata_reg : 32'd0;
  assign mem_we    = reset_n && ((state_reg == ST_WR) || (state_reg == RMW_WR));
  assign mem_a     = (reset_n && (state_reg != IDLE)) ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign mem_wd    = !mem_we ? 32'd0 : ((state_reg == ST_WR) ? wdata_reg : lane_merged);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a
// scoreboard of expected responses, latencies and write strobes.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_lat;
    logic [31:0] wa;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(8), .BIG_ENDIAN(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = mem[mem_a[9:2]];

  always @(posedge clk) begin
    if (!reset_n && $time < 30) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_we_lat);
    exp_t e;
    exp_t got_e;
    bit   acc;
    bit   got;
    int   lat;
    int   we_lat;
    logic [31:0] wa;
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    e.lat    = exp_lat;
    e.we_lat = exp_we_lat;
    e.wa     = {addr[31:2], 2'b00};
    sb.push_back(e);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) begin
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ".accept"}, {31'd0, acc}, 32'd1);
    @(posedge clk);

    got = 0; lat = 0; we_lat = 0; wa = 32'd0;
    got_e = e;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, ".busy_ready"}, {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
      end
      if (mem_we && we_lat == 0) begin
        we_lat = k;
        wa     = mem_a;
      end
      if (rsp_valid) begin
        got = 1;
        lat = k;
        got_e = sb.pop_front();
        chk({tag, ".rdata"}, rsp_rdata, got_e.rdata);
        chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, got_e.err});
        chk({tag, ".latency"}, lat, got_e.lat);
        break;
      end
    end
    if (!got) begin
      chk({tag, ".rsp_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    chk({tag, ".we_cycle"}, we_lat, got_e.we_lat);
    if (got_e.we_lat != 0) chk({tag, ".we_addr"}, wa, got_e.wa);
    @(negedge clk);
    chk({tag, ".rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;

    // 1. Reset with a request pending
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst.mem_a", mem_a, 32'd0);
    end
    reset_n   = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst.ready_after", {31'd0, req_ready}, 32'd1);

    // 2. Word store then load
    do_req("st_w10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'd0, 0, 2, 1);
    chk("mem10", mem[4], 32'hDEADBEEF);
    do_req("ld_w10", 0, 2'b10, 1, 32'h10, 32'd0, 32'hDEADBEEF, 0, 2, 0);

    // 3. Byte RMW and byte loads
    do_req("seed20", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'd0, 0, 2, 1);
    do_req("st_b21", 1, 2'b00, 0, 32'h21, 32'h000000AA, 32'd0, 0, 3, 2);
    chk("mem20_b", mem[8], 32'h1122AA44);
    do_req("ld_b21s", 0, 2'b00, 1, 32'h21, 32'd0, 32'hFFFFFFAA, 0, 2, 0);
    do_req("ld_b21u", 0, 2'b00, 0, 32'h21, 32'd0, 32'h000000AA, 0, 2, 0);
    do_req("ld_b23s", 0, 2'b00, 1, 32'h23, 32'd0, 32'h00000011, 0, 2, 0);

    // 4. Half loads and half RMW
    do_req("seed20b", 1, 2'b10, 0, 32'h20, 32'h80015566, 32'd0, 0, 2, 1);
    do_req("ld_h22s", 0, 2'b01, 1, 32'h22, 32'd0, 32'hFFFF8001, 0, 2, 0);
    do_req("ld_h20s", 0, 2'b01, 1, 32'h20, 32'd0, 32'h00005566, 0, 2, 0);
    do_req("st_h22", 1, 2'b01, 0, 32'h22, 32'hFFFF1234, 32'd0, 0, 3, 2);
    chk("mem20_h", mem[8], 32'h12345566);
    do_req("ld_h22u", 0, 2'b01, 0, 32'h22, 32'd0, 32'h00001234, 0, 2, 0);

    // Last legal word
    do_req("st_last", 1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 32'd0, 0, 2, 1);
    do_req("ld_last", 0, 2'b10, 0, 32'h3FC, 32'd0, 32'hCAFEF00D, 0, 2, 0);

    // 5. Errors: no memory access, rdata 0, latency as a load
    do_req("err_w13", 0, 2'b10, 0, 32'h13, 32'd0, 32'd0, 1, 2, 0);
    do_req("err_h21", 1, 2'b01, 0, 32'h21, 32'h5555, 32'd0, 1, 2, 0);
    do_req("err_sz3", 1, 2'b11, 0, 32'h10, 32'h77777777, 32'd0, 1, 2, 0);
    do_req("err_400", 1, 2'b10, 0, 32'h400, 32'h99999999, 32'd0, 1, 2, 0);
    chk("err.mem10", mem[4], 32'hDEADBEEF);
    chk("err.mem20", mem[8], 32'h12345566);
    chk("err.mem0", mem[0], 32'd0);

    // 6. Reset during RMW_RD of a byte store
    do_req("seed30", 1, 2'b10, 0, 32'h30, 32'h11223344, 32'd0, 0, 2, 1);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h31;
    req_wdata  = 32'h000000EE;
    chk("abort.ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("abort.mem_we", {31'd0, mem_we}, 32'd0);
      chk("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      if (c == 1) reset_n = 1'b1;
    end
    chk("abort.idle", {31'd0, req_ready}, 32'd1);
    chk("abort.mem30", mem[12], 32'h11223344);
    do_req("ld_w30", 0, 2'b10, 0, 32'h30, 32'd0, 32'h11223344, 0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
